// File: rtl/dsm_buf_pkg.sv
// ============================================================================
// Module      : dsm_buf_pkg
// Description : Shared types and constants for the DSM sample ring buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsm_buf_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      RUN  = 1'b1
   } dsm_state_e;

   // Replicated across the full sample word to form the all-zeros idle code.
   localparam logic IDLE_CODE = 1'b0;

   localparam int DEFAULT_DEPTH = 16;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

endpackage

`default_nettype wire

// File: rtl/dsm_buf_mem.sv
// ============================================================================
// Module      : dsm_buf_mem
// Description : DEPTH x DATA_W sample store, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsm_buf_mem
   import dsm_buf_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int DATA_W = 8,
   parameter int ADDR_W = ptr_width(DEPTH)
)(
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset; only written entries are ever read.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/dsm_ring_buffer.sv
// ============================================================================
// Module      : dsm_ring_buffer
// Description : Multi-channel DSM sample ring buffer with prefill gating,
//               fill level, overrun/underrun pulses and synchronous flush.
//               Optional macro DSM_BUF_STATS_EN adds saturating event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsm_ring_buffer
   import dsm_buf_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 4,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int PREFILL  = DEPTH / 2
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        wr_en,
   input  logic [CHANNELS*WIDTH-1:0]   wr_data,
   input  logic                        rd_en,
   output logic [CHANNELS*WIDTH-1:0]   rd_data,
   output logic                        rd_valid,
   output logic [$clog2(DEPTH)-1:0]    save_index,
   output logic [$clog2(DEPTH)-1:0]    read_index,
   output logic [$clog2(DEPTH):0]      level,
   output logic                        running,
   output logic                        overrun,
   output logic                        underrun
`ifdef DSM_BUF_STATS_EN
   ,
   output logic [15:0]                 overrun_count,
   output logic [15:0]                 underrun_count
`endif
);

   localparam int DATA_W = CHANNELS * WIDTH;
   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int LVL_W  = PTR_W + 1;

   localparam logic [LVL_W-1:0] c_FULL    = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] c_PREFILL = LVL_W'(PREFILL);
   localparam logic [LVL_W-1:0] c_EMPTY   = '0;

   dsm_state_e          r_state;
   logic [PTR_W-1:0]    r_save_idx;
   logic [PTR_W-1:0]    r_read_idx;
   logic [LVL_W-1:0]    r_level;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rd_valid;
   logic                r_overrun;
   logic                r_underrun;

   logic [DATA_W-1:0]   w_mem_rd;
   logic                w_active;
   logic                w_rd_req;
   logic                w_rd_serve;
   logic                w_underrun;
   logic                w_wr_acc;
   logic                w_overrun;
   logic                w_mem_we;
   logic [LVL_W-1:0]    w_level_nxt;

   // A read served in the same cycle frees the slot a full-buffer write needs.
   always_comb begin
      w_active    = rst_n & ~flush;
      w_rd_req    = (r_state == RUN) & rd_en;
      w_rd_serve  = w_rd_req & (r_level != c_EMPTY);
      w_underrun  = w_rd_req & (r_level == c_EMPTY);
      w_wr_acc    = wr_en & ((r_level != c_FULL) | w_rd_serve);
      w_overrun   = wr_en & ~w_wr_acc;
      w_mem_we    = w_wr_acc & w_active;
      w_level_nxt = r_level + LVL_W'(w_wr_acc) - LVL_W'(w_rd_serve);
   end

   dsm_buf_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_mem_we),
      .i_wr_addr (r_save_idx),
      .i_wr_data (wr_data),
      .i_rd_addr (r_read_idx),
      .o_rd_data (w_mem_rd)
   );

   always_ff @(posedge clk) begin
      if (!w_active) begin
         r_state    <= FILL;
         r_save_idx <= '0;
         r_read_idx <= '0;
         r_level    <= '0;
         r_rd_data  <= {DATA_W{IDLE_CODE}};
         r_rd_valid <= 1'b0;
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_save_idx <= r_save_idx + PTR_W'(1);
         end
         if (w_rd_serve) begin
            r_read_idx <= r_read_idx + PTR_W'(1);
            r_rd_data  <= w_mem_rd;
         end
         r_level    <= w_level_nxt;
         r_rd_valid <= w_rd_serve | w_underrun;
         r_overrun  <= w_overrun;
         r_underrun <= w_underrun;

         case (r_state)
            FILL: begin
               if (w_level_nxt >= c_PREFILL) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_underrun) begin
                  r_state <= FILL;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

`ifdef DSM_BUF_STATS_EN
   logic [15:0] r_ovr_cnt;
   logic [15:0] r_und_cnt;

   // Counters advance on the same edge that raises the matching pulse.
   always_ff @(posedge clk) begin
      if (!w_active) begin
         r_ovr_cnt <= '0;
         r_und_cnt <= '0;
      end else begin
         if (w_overrun && (r_ovr_cnt != 16'hFFFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
         end
         if (w_underrun && (r_und_cnt != 16'hFFFF)) begin
            r_und_cnt <= r_und_cnt + 16'd1;
         end
      end
   end

   assign overrun_count  = r_ovr_cnt;
   assign underrun_count = r_und_cnt;
`endif

   assign rd_data    = r_rd_data;
   assign rd_valid   = r_rd_valid;
   assign save_index = r_save_idx;
   assign read_index = r_read_idx;
   assign level      = r_level;
   assign running    = (r_state == RUN);
   assign overrun    = r_overrun;
   assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_dsm_ring_buffer.sv
// ============================================================================
// Module      : tb_dsm_ring_buffer
// Description : Directed + random bench for dsm_ring_buffer against a
//               queue-based reference model. Honours DSM_BUF_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsm_ring_buffer;

   localparam int CH = 2;
   localparam int W  = 4;
   localparam int D  = 8;
   localparam int PF = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [2:0] save_index;
   logic [2:0] read_index;
   logic [3:0] level;
   logic       running;
   logic       overrun;
   logic       underrun;
`ifdef DSM_BUF_STATS_EN
   logic [15:0] overrun_count;
   logic [15:0] underrun_count;
`endif

   dsm_ring_buffer #(
      .CHANNELS (CH),
      .WIDTH    (W),
      .DEPTH    (D),
      .PREFILL  (PF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .save_index (save_index),
      .read_index (read_index),
      .level      (level),
      .running    (running),
      .overrun    (overrun),
      .underrun   (underrun)
`ifdef DSM_BUF_STATS_EN
      ,
      .overrun_count  (overrun_count),
      .underrun_count (underrun_count)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: the stored entries live in a FIFO queue.
   logic [7:0] m_q[$];
   int         m_wptr, m_rptr;
   bit         m_run, m_vld, m_ovr, m_und;
   logic [7:0] m_rd;
   int         m_ocnt, m_ucnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_wptr = 0; m_rptr = 0;
      m_run = 0; m_vld = 0; m_ovr = 0; m_und = 0;
      m_rd = 8'h00; m_ocnt = 0; m_ucnt = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":rd_data"},    32'(rd_data),    32'(m_rd));
      chk({tag, ":rd_valid"},   32'(rd_valid),   32'(m_vld));
      chk({tag, ":save_index"}, 32'(save_index), 32'(m_wptr));
      chk({tag, ":read_index"}, 32'(read_index), 32'(m_rptr));
      chk({tag, ":level"},      32'(level),      32'(m_q.size()));
      chk({tag, ":running"},    32'(running),    32'(m_run));
      chk({tag, ":overrun"},    32'(overrun),    32'(m_ovr));
      chk({tag, ":underrun"},   32'(underrun),   32'(m_und));
`ifdef DSM_BUF_STATS_EN
      chk({tag, ":ovr_cnt"},    32'(overrun_count),  32'(m_ocnt));
      chk({tag, ":und_cnt"},    32'(underrun_count), 32'(m_ucnt));
`endif
   endtask

   task automatic step(input string tag, input bit rst, input bit fl,
                       input bit wr, input logic [7:0] wd, input bit rd);
      bit serve, under, acc;
      rst_n = ~rst; flush = fl; wr_en = wr; wr_data = wd; rd_en = rd;
      @(posedge clk);
      if (rst || fl) begin
         model_clear();
      end else begin
         serve = m_run && rd && (m_q.size() > 0);
         under = m_run && rd && (m_q.size() == 0);
         acc   = wr && ((m_q.size() < D) || serve);
         m_vld = serve || under;
         m_und = under;
         m_ovr = wr && !acc;
         if (serve) begin
            m_rd   = m_q.pop_front();
            m_rptr = (m_rptr + 1) % D;
         end
         if (acc) begin
            m_q.push_back(wd);
            m_wptr = (m_wptr + 1) % D;
         end
         if (under) m_run = 0;
         else if (!m_run && m_q.size() >= PF) m_run = 1;
         if (m_ovr && m_ocnt < 16'hFFFF) m_ocnt++;
         if (under && m_ucnt < 16'hFFFF) m_ucnt++;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [7:0] seq [4];
      seq[0] = 8'hFE; seq[1] = 8'hDC; seq[2] = 8'hBA; seq[3] = 8'h98;
      model_clear();

      step("reset0", 1, 0, 0, 8'h00, 0);
      step("reset1", 1, 0, 1, 8'h55, 1);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_rd_data", 32'(rd_data), 32'd0);

      // Prefill phase: reads ignored while filling
      for (int i = 0; i < 3; i++) step("prefill", 0, 0, 1, seq[i], 1);
      chk("prefill_save_index", 32'(save_index), 32'd3);
      chk("prefill_level", 32'(level), 32'd3);
      chk("prefill_running", 32'(running), 32'd0);
      chk("prefill_rd_data", 32'(rd_data), 32'd0);

      step("fourth_write", 0, 0, 1, seq[3], 0);
      chk("run_entered", 32'(running), 32'd1);

      for (int i = 0; i < 4; i++) begin
         step("read_seq", 0, 0, 0, 8'h00, 1);
         chk("read_seq_valid", 32'(rd_valid), 32'd1);
         chk("read_seq_data", 32'(rd_data), 32'(seq[i]));
      end
      chk("read_index_end", 32'(read_index), 32'd4);

      step("underrun", 0, 0, 0, 8'h00, 1);
      chk("underrun_pulse", 32'(underrun), 32'd1);
      chk("underrun_repeat", 32'(rd_data), 32'h98);
      chk("underrun_running", 32'(running), 32'd0);
      step("underrun_clear", 0, 0, 0, 8'h00, 0);

      for (int i = 0; i < 8; i++) step("fill8", 0, 0, 1, 8'(8'h20 + i), 0);
      chk("full_level", 32'(level), 32'd8);
      step("overrun", 0, 0, 1, 8'h11, 0);
      chk("overrun_pulse", 32'(overrun), 32'd1);
      chk("overrun_level", 32'(level), 32'd8);
      chk("overrun_save_index", 32'(save_index), 32'd4);
      step("full_wr_rd", 0, 0, 1, 8'h33, 1);
      chk("full_wr_rd_no_ovr", 32'(overrun), 32'd0);
      chk("full_wr_rd_level", 32'(level), 32'd8);

      for (int i = 0; i < 20; i++) step("wrap_pair", 0, 0, 1, 8'($urandom), 1);
      for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 8'h00, 1);
      chk("pre_flush_level", 32'(level), 32'd5);

      step("flush", 0, 1, 1, 8'hAA, 0);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_save_index", 32'(save_index), 32'd0);
      chk("flush_read_index", 32'(read_index), 32'd0);
      chk("flush_rd_data", 32'(rd_data), 32'd0);
      chk("flush_running", 32'(running), 32'd0);

      for (int i = 0; i < 600; i++) begin
         step("random", ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
              bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)));
      end

`ifdef DSM_BUF_STATS_EN
      step("stats_flush", 0, 1, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++) step("stats_fill", 0, 0, 1, 8'(i), 0);
      for (int i = 0; i < 65540; i++) step("stats_sat", 0, 0, 1, 8'hEE, 0);
      chk("ovr_cnt_saturated", 32'(overrun_count), 32'hFFFF);
      step("stats_clear", 0, 1, 0, 8'h00, 0);
      chk("ovr_cnt_cleared", 32'(overrun_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
